// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the matching receiver: data width,
// transmitter state codes, bit-period and parity helpers.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t S_IDLE   = 3'd0;
    localparam tx_state_t S_START  = 3'd1;
    localparam tx_state_t S_DATA   = 3'd2;
    localparam tx_state_t S_PARITY = 3'd3;
    localparam tx_state_t S_STOP   = 3'd4;

    function automatic int bit_clks(input int half);
        return 2 * half;
    endfunction

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. The word at the read pointer is
// always visible on pop_data, so a pop consumes the byte shown in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter, 8N1 LSB first; define UART_TX_PARITY_EN to insert an
// even-parity bit between data bit 7 and stop (11-bit frame).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [UART_DATA_W-1:0]        sdata,
    input  logic                          sdata_valid,
    output logic                          sdata_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_CLKS = bit_clks(CLK_PER_HALF_BIT);
    localparam int CW       = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
`ifdef UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = S_PARITY;
`else
    localparam tx_state_t AFTER_DATA = S_STOP;
`endif

    tx_state_t              state_r;
    logic [CW-1:0]          clk_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic [UART_DATA_W-1:0] shift_r;
    logic                   txd_r;
`ifdef UART_TX_PARITY_EN
    logic                   parity_r;
`endif
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [UART_DATA_W-1:0] pop_data_s;
    logic                   pop_s;
    logic                   bit_end_s;
    logic                   line_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (sdata_valid),
        .push_data (sdata),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count)
    );

    assign sdata_ready = !fifo_full_s;
    assign tx_busy     = (state_r != S_IDLE) || (fifo_count != '0);
    assign txd         = txd_r;
    assign bit_end_s   = (clk_cnt_r == CNT_LAST);

    // Pop when idle, or at the end of a stop bit so frames run back-to-back.
    always_comb begin
        pop_s = 1'b0;
        if (state_r == S_IDLE) begin
            pop_s = !fifo_empty_s;
        end else if ((state_r == S_STOP) && bit_end_s) begin
            pop_s = !fifo_empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Line level for the current state; registered into txd_r one cycle later.
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            S_START:  line_s = 1'b0;
            S_DATA:   line_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_s = parity_r;
`endif
            default:  line_s = 1'b1;
        endcase
    end

    // Frame sequencer, bit timer and shifter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            clk_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= '0;
            txd_r     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            txd_r     <= line_s;
            clk_cnt_r <= ((state_r == S_IDLE) || bit_end_s) ? '0 : clk_cnt_r + CW'(1);
            if (pop_s) begin
                shift_r   <= pop_data_s;
                bit_cnt_r <= 3'd0;
                state_r   <= S_START;
`ifdef UART_TX_PARITY_EN
                parity_r  <= even_parity(pop_data_s);
`endif
            end else begin
                case (state_r)
                    S_IDLE: state_r <= S_IDLE;
                    S_START: begin
                        if (bit_end_s) begin
                            state_r <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (bit_end_s) begin
                            shift_r <= {1'b0, shift_r[UART_DATA_W-1:1]};
                            if (bit_cnt_r == 3'(UART_DATA_W - 1)) begin
                                state_r <= AFTER_DATA;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (bit_end_s) begin
                            state_r <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (bit_end_s) begin
                            state_r <= S_IDLE;
                        end
                    end
                    default: state_r <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 8 clocks per bit and a 4-entry FIFO, with a model
// receiver that samples each bit mid-period and records frame start times.
module tb_uart_tx;

    localparam int HALF  = 4;
    localparam int DEPTH = 4;
    localparam int BITC  = 2 * HALF;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int L = NBITS * BITC;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [7:0] sdata = 8'h00;
    logic       sdata_valid = 1'b0;
    logic       sdata_ready;
    logic       txd;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         rx_en = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         rx_t[$];

    uart_tx #(
        .CLK_PER_HALF_BIT (HALF),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sdata       (sdata),
        .sdata_valid (sdata_valid),
        .sdata_ready (sdata_ready),
        .txd         (txd),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Model receiver: frame start index = first cycle the line is seen low.
    initial begin : model_rx
        logic [7:0] b;
        int         t0;
        forever begin
            @(posedge clk); #1;
            if (rx_en && rstn && txd === 1'b0) begin
                t0 = cyc;
                repeat (HALF) @(posedge clk);
                #1;
                check_eq("rx_start_mid", txd, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(posedge clk);
                    #1;
                    b[i] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (BITC) @(posedge clk);
                #1;
                check_eq("rx_parity", txd, ^b);
`endif
                repeat (BITC) @(posedge clk);
                #1;
                check_eq("rx_stop", txd, 1'b1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
                repeat (HALF - 1) @(posedge clk);
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        sdata       = d;
        sdata_valid = 1'b1;
        @(posedge clk); #1;
        sdata_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int g = 0;
        while (rx_q.size() < n && g < 3000) begin
            @(posedge clk);
            g++;
        end
        check_eq("rx_wait", rx_q.size(), n);
        repeat (4) @(posedge clk);
    endtask

    // Push one byte into an idle transmitter and check the line every cycle.
    task automatic frame_check(input logic [7:0] d);
        logic [NBITS-1:0] bits;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {1'b1, d, 1'b0};
`endif
        exp_q.push_back(d);
        push_byte(d);
        check_eq("cnt_after_push", fifo_count, 3'd1);
        @(posedge clk); #1;
        check_eq("line_before_start", txd, 1'b1);
        for (int i = 0; i < L; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("line_bit_%0d", i), txd, bits[i / BITC]);
            if (i == 0) check_eq("cnt_after_pop", fifo_count, 3'd0);
            if (i == L - 3) check_eq("busy_in_stop", tx_busy, 1'b1);
        end
        @(posedge clk); #1;
        check_eq("busy_after_frame", tx_busy, 1'b0);
        check_eq("line_after_frame", txd, 1'b1);
        wait_rx(exp_q.size());
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] burst [6];
        int         idx, stall, guard, base, low_cnt;
        bit         acc, ready_checked;

        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        #2 rstn = 1'b0;
        #1;
        check_eq("rst_txd", txd, 1'b1);
        check_eq("rst_ready", sdata_ready, 1'b1);
        check_eq("rst_busy", tx_busy, 1'b0);
        check_eq("rst_count", fifo_count, 3'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Idle line after reset.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check_eq("idle_txd", txd, 1'b1);
            check_eq("idle_busy", tx_busy, 1'b0);
            check_eq("idle_ready", sdata_ready, 1'b1);
        end

        rx_en = 1'b1;
        frame_check(8'h55);

        // Two consecutive pushes: second push coincides with the first pop.
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        @(negedge clk);
        sdata = 8'hA3; sdata_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("cnt_first_push", fifo_count, 3'd1);
        @(negedge clk);
        sdata = 8'h0F;
        @(posedge clk); #1;
        sdata_valid = 1'b0;
        check_eq("cnt_push_and_pop", fifo_count, 3'd1);
        wait_rx(exp_q.size());
        check_eq("b2b_spacing", rx_t[rx_t.size()-1] - rx_t[rx_t.size()-2], L);

        // Hold valid with six bytes: first is popped at once, four more fill the FIFO.
        base = exp_q.size();
        for (int i = 0; i < 6; i++) exp_q.push_back(burst[i]);
        idx = 0; stall = 0; guard = 0; ready_checked = 1'b0;
        while (idx < 6 && guard < 2000) begin
            @(negedge clk);
            sdata       = burst[idx];
            sdata_valid = 1'b1;
            acc         = sdata_ready;
            if (!acc) stall++;
            if (acc && stall > 0 && !ready_checked) begin
                check_eq("cnt_on_ready_return", fifo_count, 3'd3);
                ready_checked = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == 5) begin
                    check_eq("ready_when_full", sdata_ready, 1'b0);
                    check_eq("cnt_when_full", fifo_count, 3'd4);
                end
            end
            guard++;
        end
        sdata_valid = 1'b0;
        check_eq("burst_accepted", idx, 6);
        check_eq("full_stall_cycles", stall, L - 3);
        wait_rx(exp_q.size());
        for (int k = base + 1; k < base + 6 && k < rx_t.size(); k++) begin
            check_eq("burst_spacing", rx_t[k] - rx_t[k-1], L);
        end

`ifdef UART_TX_PARITY_EN
        frame_check(8'h07);
        frame_check(8'h03);
`endif

        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < rx_q.size()) check_eq($sformatf("rx_byte_%0d", k), rx_q[k], exp_q[k]);
        end
        check_eq("rx_total", rx_q.size(), exp_q.size());

        // Reset during data bit 3 of 0x00 with another byte queued.
        repeat (20) @(posedge clk);
        rx_en = 1'b0;
        push_byte(8'h00);
        push_byte(8'h11);
        repeat (35) @(posedge clk);
        #1;
        check_eq("line_low_bit3", txd, 1'b0);
        check_eq("cnt_before_reset", fifo_count, 3'd1);
        #2 rstn = 1'b0;
        #1;
        check_eq("txd_async_reset", txd, 1'b1);
        check_eq("cnt_async_reset", fifo_count, 3'd0);
        check_eq("busy_async_reset", tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1 || tx_busy !== 1'b0) low_cnt++;
        end
        check_eq("no_frame_after_reset", low_cnt, 0);
        check_eq("ready_after_reset", sdata_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
